// File: rtl/multiword_add_sequencer_if.sv
// Operand/result bus for the multi-word adder sequencer.
// master drives requests, slave returns busy/done and the result.
interface multiword_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int N = 16 * WORDS;

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] Sum;
  logic         Cout;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Cout
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Cout
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Wide adder built from one 16-bit ripple adder, one slice per clock,
// LSB slice first, with the inter-slice carry held in a flop.
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  multiword_add_sequencer_if.slave bus
);
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] KLAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [WORDS-1:0][15:0] a_q, a_d;
  logic [WORDS-1:0][15:0] b_q, b_d;
  logic [WORDS-1:0][15:0] work_q, work_d;
  logic [WORDS-1:0][15:0] sum_q, sum_d;
  logic                   c_q, c_d;
  logic                   cout_q, cout_d;
  logic [KW-1:0]          k_q, k_d;

  logic [15:0] add_s;
  logic        add_c;

  ripple_carry_adder_16bit u_add (
    .A    (a_q[k_q]),
    .B    (b_q[k_q]),
    .Cin  (c_q),
    .Sum  (add_s),
    .Cout (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.Cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[k_q] = add_s;
        c_d         = add_c;
        k_d         = k_q + KW'(1);
        // result is published only once the top slice lands
        if (k_q == KLAST) begin
          sum_d   = work_d;
          cout_d  = add_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;
endmodule

module ripple_carry_adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  always_comb begin
    logic cy;
    cy  = Cin;
    Sum = '0;
    for (int i = 0; i < 16; i++) begin
      Sum[i] = A[i] ^ B[i] ^ cy;
      cy     = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    Cout = cy;
  end
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer against a plain
// (WORDS*16+1)-bit arithmetic reference.
module tb_multiword_add_sequencer;
  localparam int W = 4;
  localparam int N = 16 * W;

  typedef struct packed {
    logic         c;
    logic [N-1:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multiword_add_sequencer_if #(.WORDS(W)) bus ();

  multiword_add_sequencer #(.WORDS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t model(logic [N-1:0] a, logic [N-1:0] b,
                                 logic ci);
    logic [N:0] r;
    r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    return exp_t'(r);
  endfunction

  task automatic chk(string nm, logic [N:0] act, logic [N:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    for (int i = 0; i < W; i++) v[16*i +: 16] = 16'($urandom);
    return v;
  endfunction

  // monitor: pops on done, checks held outputs otherwise
  logic [N:0] last_out = '0;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out  = '0;
      prev_done = 1'b0;
    end else if (bus.done) begin
      chk("done_pulse", {{N{1'b0}}, prev_done}, '0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {bus.Cout, bus.Sum}, {e.c, e.s});
      end
      last_out  = {bus.Cout, bus.Sum};
      prev_done = 1'b1;
    end else begin
      if (bus.busy) chk("hold", {bus.Cout, bus.Sum}, last_out);
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", {{N{1'b0}}, bus.busy}, '0);
  endtask

  task automatic run_op(logic [N-1:0] a, logic [N-1:0] b, logic ci,
                        bit scramble);
    int n;
    wait_idle();
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = ci;
    bus.start = 1'b1;
    q.push_back(model(a, b, ci));
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    chk("busy_rise", {{N{1'b0}}, bus.busy}, {{N{1'b0}}, 1'b1});
    while (!bus.done && n < 20) begin
      if (scramble) begin
        bus.A     = rnd();
        bus.B     = rnd();
        bus.Cin   = 1'($urandom);
        bus.start = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("latency", (N+1)'(n), (N+1)'(W + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int prev;
    logic [N-1:0] ones;
    ones      = '1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out", {bus.busy, bus.done, bus.Cout, bus.Sum}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op('0, '0, 1'b0, 1'b0);
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    run_op(ones, '0, 1'b1, 1'b0);
    run_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b1);

    // start held high: one accept per WORDS+2 cycles
    wait_idle();
    bus.start = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      if (i > 0) chk("period", (N+1)'(cyc - prev), (N+1)'(W + 2));
      prev    = cyc;
      bus.A   = rnd();
      bus.B   = rnd();
      bus.Cin = 1'($urandom);
      q.push_back(model(bus.A, bus.B, bus.Cin));
      @(negedge clk);
    end
    wait_idle();
    bus.start = 1'b0;
    @(negedge clk);

    // reset mid-operation
    bus.A     = 64'h0F0F;
    bus.B     = 64'h0101;
    bus.Cin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort", {bus.busy, bus.done, bus.Cout, bus.Sum}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", {bus.busy, bus.done, bus.Cout, bus.Sum}, '0);
    run_op(ones, ones, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(rnd(), rnd(), 1'($urandom), i[0]);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", (N+1)'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
